// File: rtl/mic_spi_master_pkg.sv
// Shared types and defaults for the microphone SPI master.
// Holds the FSM state encoding, default parameters and a counter-width helper.
package mic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SHIFT = 2'd2,
      ST_QUIET = 2'd3
   } mic_state_e;

   localparam int DEF_CLK_DIV      = 4;
   localparam int DEF_FRAME_BITS   = 16;
   localparam int DEF_DATA_BITS    = 12;
   localparam int DEF_NUM_CH       = 1;
   localparam int DEF_QUIET_CYCLES = 8;

   // Bits needed to hold the values 0..max_val inclusive.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mic_spi_master_if.sv
// Bundle between the SPI master and its surroundings: serial pins, result stream, control.
// The master modport is the DUT side; slave is the microphone/consumer side.
interface mic_spi_master_if #(
   parameter int NUM_CH    = mic_pkg::DEF_NUM_CH,
   parameter int DATA_BITS = mic_pkg::DEF_DATA_BITS
);

   logic                          enable;
   logic                          start;
   logic [NUM_CH-1:0]             sdata;
   logic                          sck;
   logic                          cs_n;
   logic [NUM_CH*DATA_BITS-1:0]   sample_data;
   logic                          sample_valid;
   logic                          sample_ready;
   logic                          busy;
   logic                          overrun;
   logic                          overrun_clr;

   modport master (
      input  enable, start, sdata, sample_ready, overrun_clr,
      output sck, cs_n, sample_data, sample_valid, busy, overrun
   );

   modport slave (
      output enable, start, sdata, sample_ready, overrun_clr,
      input  sck, cs_n, sample_data, sample_valid, busy, overrun
   );

endinterface

// File: rtl/mic_spi_master_divider.sv
// SCK half-period tick generator: pulses tick every CLK_DIV cycles while run is high.
// The count restarts from zero whenever run drops, so each frame starts phase-aligned.
module sck_divider
   import mic_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV
)(
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic tick
);

   localparam int             CW   = cnt_width(CLK_DIV - 1);
   localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (!run || (r_cnt == LAST)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign tick = run && (r_cnt == LAST);

endmodule

// File: rtl/mic_spi_master.sv
// Multi-channel SPI master for serial ADC microphones: one frame per request or back-to-back.
// Result loads on the cycle cs_n rises; an unconsumed result is overwritten and flagged as overrun.
module mic_spi_master
   import mic_pkg::*;
#(
   parameter int CLK_DIV      = DEF_CLK_DIV,
   parameter int FRAME_BITS   = DEF_FRAME_BITS,
   parameter int DATA_BITS    = DEF_DATA_BITS,
   parameter int NUM_CH       = DEF_NUM_CH,
   parameter int QUIET_CYCLES = DEF_QUIET_CYCLES
)(
   input  logic             clk,
   input  logic             rst_n,
   mic_spi_master_if.master bus
);

   localparam int              RW         = NUM_CH * DATA_BITS;
   localparam int              BCW        = cnt_width(FRAME_BITS);
   localparam int              QCW        = cnt_width(QUIET_CYCLES);
   localparam logic [BCW-1:0]  BIT_LAST   = BCW'(FRAME_BITS);
   localparam logic [QCW-1:0]  QUIET_LAST = QCW'(QUIET_CYCLES - 1);

   mic_state_e     r_state;
   logic           r_sck;
   logic           r_cs_n;
   logic           r_busy;
   logic [BCW-1:0] r_bit_cnt;
   logic [QCW-1:0] r_quiet_cnt;
   logic [RW-1:0]  r_sample_data;
   logic           r_sample_valid;
   logic           r_overrun;

   logic           w_run;
   logic           w_tick;
   logic           w_shift;
   logic           w_load;
   logic           w_xfer;
   logic [RW-1:0]  w_result;

   assign w_run = (r_state == ST_SETUP) || (r_state == ST_SHIFT);

   sck_divider #(
      .CLK_DIV (CLK_DIV)
   ) u_sck_divider (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (w_run),
      .tick  (w_tick)
   );

   // A tick with sck low is a rising edge; with sck high after the last bit it ends the frame.
   assign w_shift = (r_state == ST_SHIFT) && w_tick && !r_sck;
   assign w_load  = (r_state == ST_SHIFT) && w_tick && r_sck && (r_bit_cnt == BIT_LAST);
   assign w_xfer  = r_sample_valid && bus.sample_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_sck       <= 1'b1;
         r_cs_n      <= 1'b1;
         r_busy      <= 1'b0;
         r_bit_cnt   <= '0;
         r_quiet_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.enable || bus.start) begin
                  r_state   <= ST_SETUP;
                  r_cs_n    <= 1'b0;
                  r_busy    <= 1'b1;
                  r_bit_cnt <= '0;
               end
            end
            ST_SETUP: begin
               if (w_tick) begin
                  r_state <= ST_SHIFT;
                  r_sck   <= 1'b0;
               end
            end
            ST_SHIFT: begin
               if (w_tick) begin
                  if (!r_sck) begin
                     r_sck     <= 1'b1;
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end else if (r_bit_cnt == BIT_LAST) begin
                     r_state     <= ST_QUIET;
                     r_cs_n      <= 1'b1;
                     r_quiet_cnt <= '0;
                  end else begin
                     r_sck <= 1'b0;
                  end
               end
            end
            ST_QUIET: begin
               if (r_quiet_cnt == QUIET_LAST) begin
                  if (bus.enable) begin
                     r_state   <= ST_SETUP;
                     r_cs_n    <= 1'b0;
                     r_bit_cnt <= '0;
                  end else begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_quiet_cnt <= r_quiet_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_sck   <= 1'b1;
               r_cs_n  <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Only the newest DATA_BITS bits are kept, so the leading bits of a frame fall off the top.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [DATA_BITS-1:0] r_shift;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_shift <= '0;
         end else if (w_shift) begin
            r_shift <= DATA_BITS'({r_shift, bus.sdata[g]});
         end
      end

      assign w_result[g*DATA_BITS +: DATA_BITS] = r_shift;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sample_data  <= '0;
         r_sample_valid <= 1'b0;
         r_overrun      <= 1'b0;
      end else begin
         if (w_load) begin
            r_sample_data  <= w_result;
            r_sample_valid <= 1'b1;
         end else if (w_xfer) begin
            r_sample_valid <= 1'b0;
         end
         // A load that coincides with a transfer replaces consumed data, so it is not an overrun.
         if (w_load && r_sample_valid && !bus.sample_ready) begin
            r_overrun <= 1'b1;
         end else if (bus.overrun_clr) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign bus.sck          = r_sck;
   assign bus.cs_n         = r_cs_n;
   assign bus.busy         = r_busy;
   assign bus.sample_data  = r_sample_data;
   assign bus.sample_valid = r_sample_valid;
   assign bus.overrun      = r_overrun;

endmodule

// File: tb/tb_mic_spi_master.sv
// Bench for mic_spi_master: microphone model on the serial pins, queue-based result model,
// fixed frame table plus random back-to-back frames and hand-built corner sequences.
module tb_mic_spi_master;

   localparam int CLK_DIV      = 2;
   localparam int FRAME_BITS   = 16;
   localparam int DATA_BITS    = 12;
   localparam int NUM_CH       = 2;
   localparam int QUIET_CYCLES = 4;
   localparam int RW           = NUM_CH * DATA_BITS;
   localparam int CS_LOW       = 66;

   typedef struct packed {
      logic [15:0] w1;
      logic [15:0] w0;
   } pair_t;

   typedef struct {
      logic [15:0]   w0;
      logic [15:0]   w1;
      logic [RW-1:0] exp_data;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   mic_spi_master_if #(.NUM_CH(NUM_CH), .DATA_BITS(DATA_BITS)) bus ();

   mic_spi_master #(
      .CLK_DIV      (CLK_DIV),
      .FRAME_BITS   (FRAME_BITS),
      .DATA_BITS    (DATA_BITS),
      .NUM_CH       (NUM_CH),
      .QUIET_CYCLES (QUIET_CYCLES)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int            n_cmp = 0;
   int            n_bad = 0;
   pair_t         tx_q[$];
   logic [RW-1:0] exp_q[$];

   pair_t cur;
   int    idx, rises, low_len, gap;
   int    last_low_len, last_rises, last_gap;
   int    frames = 0;
   logic  prev_cs, prev_sck;

   // Result of a frame: the trailing DATA_BITS of each channel's word.
   function automatic logic [RW-1:0] model(input pair_t p);
      logic [RW-1:0] r;
      r = '0;
      r[0 +: DATA_BITS]         = p.w0[DATA_BITS-1:0];
      r[DATA_BITS +: DATA_BITS] = p.w1[DATA_BITS-1:0];
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Microphone: presents bit (15 - rises seen) of its word, and measures frame timing.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_cs   = 1'b1;
         prev_sck  = 1'b1;
         idx       = 0;
         rises     = 0;
         low_len   = 0;
         gap       = 0;
         bus.sdata = '0;
      end else begin
         if (!bus.cs_n) begin
            if (prev_cs) begin
               if (tx_q.size() > 0) cur = tx_q.pop_front();
               else                 cur = pair_t'({16'($urandom), 16'($urandom)});
               exp_q.push_back(model(cur));
               frames++;
               last_gap = gap;
               low_len  = 0;
               rises    = 0;
               idx      = 0;
            end
            low_len++;
            if (bus.sck && !prev_sck) begin
               rises++;
               idx++;
            end
         end else begin
            if (!prev_cs) begin
               last_low_len = low_len;
               last_rises   = rises;
               gap          = 0;
            end
            gap++;
         end
         bus.sdata[0] = (idx < 16) ? cur.w0[15-idx] : 1'b0;
         bus.sdata[1] = (idx < 16) ? cur.w1[15-idx] : 1'b0;
         prev_cs  = bus.cs_n;
         prev_sck = bus.sck;
      end
   end

   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!bus.sample_valid && n < 400) begin
         @(negedge clk);
         n++;
      end
      check(name, 64'(bus.sample_valid), 64'(1));
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (bus.busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      check(name, 64'(bus.busy), 64'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t          vecs[4];
      logic [RW-1:0] got[$];
      int            n, f;

      bus.enable       = 1'b0;
      bus.start        = 1'b0;
      bus.sample_ready = 1'b0;
      bus.overrun_clr  = 1'b0;

      vecs[0] = '{16'h0ABC, 16'h0123, 24'h123ABC};
      vecs[1] = '{16'hFFFF, 16'h0000, 24'h000FFF};
      vecs[2] = '{16'hA5A5, 16'h5A5A, 24'hA5A5A5};
      vecs[3] = '{16'hF000, 16'h8001, 24'h001000};

      repeat (3) @(negedge clk);
      check("rst_sck",     64'(bus.sck), 64'(1));
      check("rst_cs_n",    64'(bus.cs_n), 64'(1));
      check("rst_valid",   64'(bus.sample_valid), 64'(0));
      check("rst_data",    64'(bus.sample_data), 64'(0));
      check("rst_busy",    64'(bus.busy), 64'(0));
      check("rst_overrun", 64'(bus.overrun), 64'(0));

      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("idle_no_frame", 64'(frames), 64'(0));
      check("idle_busy",     64'(bus.busy), 64'(0));

      for (int i = 0; i < 4; i++) begin
         tx_q.push_back(pair_t'({vecs[i].w1, vecs[i].w0}));
         pulse_start();
         wait_valid($sformatf("shot%0d_valid", i));
         check($sformatf("shot%0d_data", i), 64'(bus.sample_data), 64'(vecs[i].exp_data));
         n = 0;
         while (bus.busy && n < 50) begin
            @(negedge clk);
            n++;
         end
         check($sformatf("shot%0d_busy_tail", i), 64'(n), 64'(QUIET_CYCLES));
         check($sformatf("shot%0d_cs_low", i), 64'(last_low_len), 64'(CS_LOW));
         check($sformatf("shot%0d_rises", i), 64'(last_rises), 64'(FRAME_BITS));
         bus.sample_ready = 1'b1;
         @(negedge clk);
         bus.sample_ready = 1'b0;
         check($sformatf("shot%0d_consumed", i), 64'(bus.sample_valid), 64'(0));
      end

      f = frames;
      pulse_start();
      repeat (10) @(negedge clk);
      pulse_start();
      wait_valid("busy_start_valid");
      wait_idle("busy_start_idle");
      repeat (40) @(negedge clk);
      check("busy_start_ignored", 64'(frames), 64'(f + 1));
      bus.sample_ready = 1'b1;
      @(negedge clk);
      bus.sample_ready = 1'b0;

      exp_q.delete();
      tx_q.delete();
      repeat (3) tx_q.push_back(pair_t'({16'($urandom), 16'($urandom)}));
      bus.sample_ready = 1'b1;
      bus.enable       = 1'b1;
      got.delete();
      n = 0;
      while (got.size() < 3 && n < 1000) begin
         @(negedge clk);
         n++;
         if (bus.sample_valid && bus.sample_ready) got.push_back(bus.sample_data);
      end
      check("cont_count", 64'(got.size()), 64'(3));
      for (int k = 0; k < got.size(); k++) begin
         if (exp_q.size() > 0) check($sformatf("cont_data%0d", k), 64'(got[k]), 64'(exp_q.pop_front()));
      end
      check("cont_gap", 64'(last_gap), 64'(QUIET_CYCLES));

      n = 0;
      while (bus.cs_n && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (10) @(negedge clk);
      bus.enable = 1'b0;
      n = 0;
      while (!(bus.sample_valid && bus.sample_ready) && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("cont_tail_valid", 64'(bus.sample_valid), 64'(1));
      if (exp_q.size() > 0) check("cont_tail_data", 64'(bus.sample_data), 64'(exp_q.pop_front()));
      wait_idle("cont_tail_idle");
      check("cont_tail_cs_low", 64'(last_low_len), 64'(CS_LOW));
      f = frames;
      repeat (30) @(negedge clk);
      check("cont_stopped", 64'(frames), 64'(f));
      bus.sample_ready = 1'b0;

      tx_q.push_back(pair_t'({16'hFEDC, 16'h1234}));
      tx_q.push_back(pair_t'({16'h7070, 16'h0F0F}));
      bus.enable = 1'b1;
      wait_valid("ovr_first_valid");
      check("ovr_first_data", 64'(bus.sample_data), 64'(24'hEDC234));
      check("ovr_first_flag", 64'(bus.overrun), 64'(0));
      n = 0;
      while (!bus.overrun && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("ovr_set",   64'(bus.overrun), 64'(1));
      check("ovr_data",  64'(bus.sample_data), 64'(24'h070F0F));
      check("ovr_valid", 64'(bus.sample_valid), 64'(1));
      bus.enable = 1'b0;
      wait_idle("ovr_idle");
      bus.overrun_clr = 1'b1;
      @(negedge clk);
      bus.overrun_clr = 1'b0;
      check("ovr_clr",         64'(bus.overrun), 64'(0));
      check("ovr_hold_valid",  64'(bus.sample_valid), 64'(1));
      check("ovr_hold_data",   64'(bus.sample_data), 64'(24'h070F0F));

      // Raise ready only for the edge on which cs_n rises, 66 cycles after the start edge.
      tx_q.push_back(pair_t'({16'h5555, 16'hAAAA}));
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n = 1;
      while (n < CS_LOW) begin
         @(negedge clk);
         n++;
      end
      bus.sample_ready = 1'b1;
      @(negedge clk);
      bus.sample_ready = 1'b0;
      check("col_cs_high", 64'(bus.cs_n), 64'(1));
      check("col_valid",   64'(bus.sample_valid), 64'(1));
      check("col_data",    64'(bus.sample_data), 64'(24'h555AAA));
      check("col_overrun", 64'(bus.overrun), 64'(0));
      wait_idle("col_idle");

      check("rst_pre_valid", 64'(bus.sample_valid), 64'(1));
      tx_q.push_back(pair_t'({16'h1248, 16'h8421}));
      pulse_start();
      n = 0;
      while (!(rises >= 5 && !bus.sck) && n < 400) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("rst_mid_reached", 64'(rises >= 5), 64'(1));
      rst_n = 1'b0;
      #1;
      check("rst_mid_cs_n",  64'(bus.cs_n), 64'(1));
      check("rst_mid_sck",   64'(bus.sck), 64'(1));
      check("rst_mid_valid", 64'(bus.sample_valid), 64'(0));
      check("rst_mid_busy",  64'(bus.busy), 64'(0));
      check("rst_mid_data",  64'(bus.sample_data), 64'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tx_q.delete();
      exp_q.delete();
      @(negedge clk);
      tx_q.push_back(pair_t'({16'hF00D, 16'h0FED}));
      pulse_start();
      wait_valid("rst_after_valid");
      check("rst_after_data", 64'(bus.sample_data), 64'(24'h00DFED));
      wait_idle("rst_after_idle");
      check("rst_after_cs_low", 64'(last_low_len), 64'(CS_LOW));
      check("rst_after_rises",  64'(last_rises), 64'(FRAME_BITS));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mic_spi_master.md
MIC_SPI_MASTER -- requirements
Module: mic_spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per SCK half-period; legal range >=1.
REQ-002 Parameter FRAME_BITS, default 16: SCK cycles per conversion frame.
REQ-003 Parameter DATA_BITS, default 12: result bits kept per channel; legal range 1..FRAME_BITS.
REQ-004 Parameter NUM_CH, default 1: number of serial data inputs sharing SCK and CS_n.
REQ-005 Parameter QUIET_CYCLES, default 8: minimum clk cycles CS_n stays high between frames; legal range >=1.
REQ-006 clk  in  1  system clock; every flop is clocked on its rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 enable  in  1  high = run frames back-to-back.
REQ-009 start  in  1  one-cycle pulse that requests a single frame while enable=0.
REQ-010 sdata  in  NUM_CH  serial data, one bit per microphone; bit i belongs to channel i.
REQ-011 sck  out  1  serial clock, registered, idles high.
REQ-012 cs_n  out  1  chip select, registered, active low.
REQ-013 sample_data  out  NUM_CH*DATA_BITS  result word; channel i occupies bits [i*DATA_BITS +: DATA_BITS].
REQ-014 sample_valid  out  1  sample_data holds an unconsumed result.
REQ-015 sample_ready  in  1  consumer accepts the result; the transfer occurs on a cycle where sample_valid=1 and sample_ready=1.
REQ-016 busy  out  1  high whenever the FSM is not in IDLE.
REQ-017 overrun  out  1  sticky flag: an unconsumed result was overwritten.
REQ-018 overrun_clr  in  1  one-cycle pulse that clears overrun.

Function
REQ-019 The FSM SHALL use four states: IDLE, SETUP, SHIFT and QUIET.
- IDLE -> SETUP when enable=1, or when start=1.
- SETUP: cs_n=0, sck=1, lasts CLK_DIV cycles, then -> SHIFT.
- SHIFT: FRAME_BITS SCK periods; each period is CLK_DIV cycles low followed by CLK_DIV cycles high.
- QUIET: cs_n=1, lasts QUIET_CYCLES cycles.
- QUIET -> SETUP if enable=1; otherwise QUIET -> IDLE.
REQ-020 On the clk edge where sck goes 0->1, each channel SHALL shift in its sdata bit, MSB first.
REQ-021 The first FRAME_BITS-DATA_BITS bits of each frame SHALL be discarded; the last DATA_BITS bits form the result.
REQ-022 cs_n SHALL be low for exactly CLK_DIV*(1+2*FRAME_BITS) clk cycles per frame.
REQ-023 On the cycle SHIFT -> QUIET, cs_n SHALL rise, sample_data SHALL load all channels, and sample_valid SHALL become 1.
REQ-024 sample_valid SHALL clear on transfer, unless a new result loads in the same cycle; in that case it stays 1 and no overrun is flagged.
REQ-025 A result that loads while sample_valid=1 and sample_ready=0 SHALL replace the old data and set overrun.
REQ-026 overrun_clr SHALL clear overrun; if an overrun occurs in the same cycle, the set wins.
REQ-027 Deasserting enable mid-frame SHALL NOT abort the frame; the frame completes, then QUIET, then IDLE.
REQ-028 start while busy=1 SHALL be ignored.
REQ-029 sample_data SHALL remain stable while sample_valid=1 and no new result loads.

Reset
REQ-030 While rst_n=0, outputs SHALL take these values immediately (asynchronously), including mid-frame:
- state=IDLE, sck=1, cs_n=1;
- sample_data=0, sample_valid=0, overrun=0, busy=0;
- all counters and shift registers cleared.
REQ-031 The first frame after reset release SHALL begin only on enable=1 or start=1; no partial frame is emitted.

Structure
REQ-032 A shared package mic_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-033 The SCK half-period tick counter SHALL be one sub-module, sck_divider: inputs clk, rst_n, run; output tick; parameter CLK_DIV.
REQ-034 The per-channel shift registers SHALL be a generate loop over NUM_CH inside mic_spi_master.

Verification (CLK_DIV=2, FRAME_BITS=16, DATA_BITS=12, NUM_CH=2, QUIET_CYCLES=4)
REQ-035 Single shot: start pulse with a model driving ch0=0x0ABC and ch1=0x0123 -> cs_n low for 66 cycles, 16 rising sck edges, sample_data=0x123_ABC, sample_valid=1, busy drops 4 cycles after cs_n rises.
REQ-036 Continuous: enable=1, sample_ready=1 -> cs_n high for exactly 4 cycles between frames; three consecutive results all match the model.
REQ-037 Overrun: enable=1, sample_ready=0 across two frames -> second result replaces the first and overrun=1; an overrun_clr pulse -> overrun=0.
REQ-038 Collision: sample_ready=1 on exactly the load cycle with valid=1 -> new data shown, valid stays 1, overrun stays 0.
REQ-039 Reset mid-frame: rst_n=0 after 5 sck edges -> cs_n=1, sck=1, valid=0 in the same cycle; after release, the next start yields a correct full frame.
